// File: rtl/calc_scheduler.sv
// Issue/track sequencer for the shared multi-cycle MULT/DIV unit in EX; drives pipeline stall/bubble conds.
// Optional watchdog exit from BUSY enabled by defining CALC_WDOG_EN.
module calc_scheduler #(
  parameter int CALC_CYCLES = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_stall,
  input  logic        req,
  input  logic [1:0]  req_op,
  input  logic        ovf_flush,
  input  logic        cal_finish,
  output logic        cal_start,
  output logic [1:0]  cal_op,
  output logic        cal_busy,
  output logic        hilo_we,
  output logic [1:0]  cond_front,
  output logic [1:0]  cond_back,
  output logic [31:0] stall_cnt,
  output logic        timeout
);

  // state | meaning
  // IDLE  | waiting for a calc request from EX decode
  // ISSUE | start pulse to calculator, watchdog counter loaded
  // BUSY  | calculator running, pipeline stalled
  // DONE  | HI/LO commit strobe, pipeline released
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  localparam logic [1:0] COND_FLOW  = 2'b00;
  localparam logic [1:0] COND_STALL = 2'b01;
  localparam logic [1:0] COND_ZERO  = 2'b10;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cal_op_q, cal_op_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
`ifdef CALC_WDOG_EN
  logic              timeout_q, timeout_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cal_op_q    <= 2'b00;
      stall_cnt_q <= 32'd0;
`ifdef CALC_WDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cal_op_q    <= cal_op_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef CALC_WDOG_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cal_op_d = cal_op_q;
`ifdef CALC_WDOG_EN
    timeout_d = timeout_q;
`endif
    // a program-load freeze holds everything, including a pending ISSUE
    if (!cpu_stall) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_d  = ISSUE;
            cal_op_d = req_op;
          end
        end
        ISSUE: begin
          cnt_d   = CNT_W'(CALC_CYCLES - 1);
          state_d = BUSY;
        end
        BUSY: begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          if (cal_finish) begin
            state_d = DONE;
`ifdef CALC_WDOG_EN
          end else if (cnt_q == '0) begin
            state_d   = DONE;
            timeout_d = 1'b1;
`endif
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cond_front = COND_FLOW;
    cond_back  = COND_FLOW;
    if (cpu_stall) begin
      cond_front = COND_STALL;
      cond_back  = COND_STALL;
    end else begin
      case (state_q)
        ISSUE, BUSY: begin
          cond_front = COND_STALL;
          cond_back  = COND_ZERO;
        end
        IDLE: begin
          if (req) begin
            cond_front = COND_STALL;
            cond_back  = COND_ZERO;
          end else if (ovf_flush) begin
            cond_back = COND_ZERO;
          end
        end
        default: begin
          cond_front = COND_FLOW;
          cond_back  = COND_FLOW;
        end
      endcase
    end
  end

  // only stalls caused by the calculator path are counted, not program-load freezes
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!cpu_stall && (cond_front == COND_STALL)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  assign cal_start = (state_q == ISSUE);
  assign cal_busy  = (state_q == ISSUE) || (state_q == BUSY);
  assign hilo_we   = (state_q == DONE);
  assign cal_op    = cal_op_q;
  assign stall_cnt = stall_cnt_q;
`ifdef CALC_WDOG_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_calc_scheduler.sv
// Self-checking bench for calc_scheduler: directed ops with a queue of expected ops checked at each HI/LO strobe.
module tb_calc_scheduler;

  localparam logic [1:0] C_FLOW  = 2'b00;
  localparam logic [1:0] C_STALL = 2'b01;
  localparam logic [1:0] C_ZERO  = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_stall = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic        ovf_flush = 1'b0;
  logic        cal_finish = 1'b0;
  logic        cal_start;
  logic [1:0]  cal_op;
  logic        cal_busy;
  logic        hilo_we;
  logic [1:0]  cond_front;
  logic [1:0]  cond_back;
  logic [31:0] stall_cnt;
  logic        timeout;

  calc_scheduler #(.CALC_CYCLES(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .cpu_stall(cpu_stall), .req(req), .req_op(req_op),
    .ovf_flush(ovf_flush), .cal_finish(cal_finish), .cal_start(cal_start),
    .cal_op(cal_op), .cal_busy(cal_busy), .hilo_we(hilo_we),
    .cond_front(cond_front), .cond_back(cond_back), .stall_cnt(stall_cnt),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          hilo_seen = 0;
  int          n_done = 0;
  logic [31:0] exp_stall = 32'd0;
  logic [1:0]  exp_op_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && hilo_we) begin
      hilo_seen++;
      check_val("sb_nonempty", 32'(exp_op_q.size() > 0), 32'd1);
      if (exp_op_q.size() > 0) check_val("hilo_op", 32'(cal_op), 32'(exp_op_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cond(input string tag, input logic [1:0] f, input logic [1:0] b);
    check_val({tag, "_front"}, 32'(cond_front), 32'(f));
    check_val({tag, "_back"},  32'(cond_back),  32'(b));
  endtask

  // entry/exit at posedge+1 in IDLE; finish asserted in the last of busy_cycles BUSY cycles
  task automatic do_op(input logic [1:0] op, input int busy_cycles, input bit req_in_done);
    req = 1'b1; req_op = op;
    exp_op_q.push_back(op);
    #1 check_cond("idle_req", C_STALL, C_ZERO);
    tick();
    req = 1'b0; req_op = 2'b00;
    #1;
    check_val("issue_start", 32'(cal_start), 32'd1);
    check_val("issue_busy", 32'(cal_busy), 32'd1);
    check_val("issue_op", 32'(cal_op), 32'(op));
    check_cond("issue", C_STALL, C_ZERO);
    tick();
    for (int i = 1; i <= busy_cycles; i++) begin
      if (i == busy_cycles) cal_finish = 1'b1;
      #1;
      check_val("busy_start", 32'(cal_start), 32'd0);
      check_cond("busy", C_STALL, C_ZERO);
      tick();
    end
    cal_finish = 1'b0;
    exp_stall += 32'(2 + busy_cycles);
    if (req_in_done) req = 1'b1;
    #1;
    check_val("done_hilo", 32'(hilo_we), 32'd1);
    check_val("done_busy", 32'(cal_busy), 32'd0);
    check_val("done_op", 32'(cal_op), 32'(op));
    check_val("done_stall_cnt", stall_cnt, exp_stall);
    check_cond("done", C_FLOW, C_FLOW);
    n_done++;
    tick();
    req = 1'b0;
    #1 check_val("idle_hilo", 32'(hilo_we), 32'd0);
    if (req_in_done) begin
      tick();
      check_val("no_retrigger", 32'(cal_start), 32'd0);
      check_val("no_retrigger_busy", 32'(cal_busy), 32'd0);
    end
  endtask

  initial begin
    #2;
    check_val("rst_start", 32'(cal_start), 32'd0);
    check_val("rst_busy", 32'(cal_busy), 32'd0);
    check_val("rst_hilo", 32'(hilo_we), 32'd0);
    check_val("rst_op", 32'(cal_op), 32'd0);
    check_val("rst_stall_cnt", stall_cnt, 32'd0);
    check_val("rst_timeout", 32'(timeout), 32'd0);
    check_cond("rst", C_FLOW, C_FLOW);
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1: basic op, 31 BUSY cycles -> 33 stalled cycles in total
    do_op(2'b01, 31, 1'b0);
    check_val("t1_stall_cnt", stall_cnt, 32'd33);
    check_val("t1_timeout", 32'(timeout), 32'd0);

    // 2: program-load freeze mid-BUSY
    req = 1'b1; req_op = 2'b10;
    exp_op_q.push_back(2'b10);
    tick();
    req = 1'b0; req_op = 2'b00;
    tick();
    for (int i = 1; i <= 10; i++) tick();
    exp_stall += 32'd12;
    cpu_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_cond("frz_busy", C_STALL, C_STALL);
      check_val("frz_busy_flag", 32'(cal_busy), 32'd1);
      check_val("frz_stall_cnt", stall_cnt, exp_stall);
      tick();
    end
    cpu_stall = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) cal_finish = 1'b1;
      tick();
    end
    cal_finish = 1'b0;
    exp_stall += 32'd5;
    #1;
    check_val("t2_hilo", 32'(hilo_we), 32'd1);
    check_val("t2_stall_cnt", stall_cnt, exp_stall);
    n_done++;
    tick();

    // 3: freeze in ISSUE and finish pulse in ISSUE; ovf ignored in BUSY; req in DONE ignored
    req = 1'b1; req_op = 2'b11;
    exp_op_q.push_back(2'b11);
    tick();
    req = 1'b0; req_op = 2'b00;
    cpu_stall = 1'b1; cal_finish = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("frz_issue_start", 32'(cal_start), 32'd1);
      check_cond("frz_issue", C_STALL, C_STALL);
      tick();
    end
    cpu_stall = 1'b0;
    #1 check_val("issue_release_start", 32'(cal_start), 32'd1);
    tick();
    cal_finish = 1'b0;
    exp_stall += 32'd2;
    #1;
    check_val("fin_in_issue_busy", 32'(cal_busy), 32'd1);
    check_val("fin_in_issue_hilo", 32'(hilo_we), 32'd0);
    check_val("fin_in_issue_start", 32'(cal_start), 32'd0);
    ovf_flush = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) cal_finish = 1'b1;
      #1 check_cond("busy_ovf", C_STALL, C_ZERO);
      tick();
    end
    cal_finish = 1'b0; ovf_flush = 1'b0;
    exp_stall += 32'd4;
    req = 1'b1;
    #1;
    check_val("t3_hilo", 32'(hilo_we), 32'd1);
    check_cond("done_req", C_FLOW, C_FLOW);
    n_done++;
    tick();
    req = 1'b0;
    tick();
    check_val("t3_no_retrigger", 32'(cal_start), 32'd0);
    check_val("t3_stall_cnt", stall_cnt, exp_stall);

    // 4: overflow flush in IDLE
    ovf_flush = 1'b1;
    #1 check_cond("idle_ovf", C_FLOW, C_ZERO);
    tick();
    ovf_flush = 1'b0;
    #1;
    check_cond("idle_after_ovf", C_FLOW, C_FLOW);
    check_val("ovf_no_start", 32'(cal_start), 32'd0);
    check_val("ovf_stall_cnt", stall_cnt, exp_stall);

    // DONE-cycle req handled by the generic op as well
    do_op(2'b10, 7, 1'b1);

    // 5: asynchronous reset during BUSY cycle 10
    req = 1'b1; req_op = 2'b11;
    tick();
    req = 1'b0; req_op = 2'b00;
    tick();
    for (int i = 1; i < 10; i++) tick();
    #2 rst = 1'b0;
    exp_op_q.delete();
    exp_stall = 32'd0;
    #1;
    check_val("arst_busy", 32'(cal_busy), 32'd0);
    check_val("arst_start", 32'(cal_start), 32'd0);
    check_val("arst_op", 32'(cal_op), 32'd0);
    check_val("arst_stall_cnt", stall_cnt, 32'd0);
    check_cond("arst", C_FLOW, C_FLOW);
    tick();
    rst = 1'b1;
    tick();
    do_op(2'b01, 5, 1'b0);

    // 6: finish coincides with counter reaching zero, then a run with no finish
    do_op(2'b10, 32, 1'b0);
    check_val("cnt0_fin_timeout", 32'(timeout), 32'd0);
`ifdef CALC_WDOG_EN
    req = 1'b1; req_op = 2'b11;
    exp_op_q.push_back(2'b11);
    tick();
    req = 1'b0; req_op = 2'b00;
    tick();
    for (int i = 1; i <= 32; i++) begin
      #1 check_val("wdog_busy", 32'(cal_busy), 32'd1);
      tick();
    end
    exp_stall += 32'd34;
    #1;
    check_val("wdog_hilo", 32'(hilo_we), 32'd1);
    check_val("wdog_timeout", 32'(timeout), 32'd1);
    check_val("wdog_stall_cnt", stall_cnt, exp_stall);
    n_done++;
    tick();
    do_op(2'b01, 3, 1'b0);
    check_val("wdog_sticky", 32'(timeout), 32'd1);
`else
    req = 1'b1; req_op = 2'b11;
    exp_op_q.push_back(2'b11);
    tick();
    req = 1'b0; req_op = 2'b00;
    tick();
    for (int i = 1; i <= 40; i++) tick();
    #1;
    check_val("nowdog_busy", 32'(cal_busy), 32'd1);
    check_val("nowdog_hilo", 32'(hilo_we), 32'd0);
    check_val("nowdog_timeout", 32'(timeout), 32'd0);
    cal_finish = 1'b1;
    tick();
    cal_finish = 1'b0;
    exp_stall += 32'd43;
    #1;
    check_val("nowdog_done", 32'(hilo_we), 32'd1);
    check_val("nowdog_stall_cnt", stall_cnt, exp_stall);
    n_done++;
    tick();
`endif

    tick();
    check_val("hilo_count", 32'(hilo_seen), 32'(n_done));
    check_val("sb_empty", 32'(exp_op_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
